nois_mem_copy_master: RTL and testbench

//  Avalon-MM master that copies a block of 32-bit words from one region of on-chip memory to another.

---
 rtl/nois_pkg.sv | 15 +
 rtl/nois_mem_copy_master_if.sv | 24 ++
 rtl/nois_mem_copy_master.sv | 163 ++++++++++++++++
 tb/tb_nois_mem_copy_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nois_pkg.sv
// Shared definitions for the memory-copy master: FSM states and bus constants.
package nois_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BE_ALL         = 4'hF;

endpackage

// File: rtl/nois_mem_copy_master_if.sv
// Avalon-MM master/slave signal bundle used between the copy engine and the interconnect.
interface nois_mem_copy_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/nois_mem_copy_master.sv
// Avalon-MM block copier: single-word read then write, one transaction in flight,
// with a running mod-2^32 checksum of the copied words.
module nois_mem_copy_master
    import nois_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 11,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      src_addr,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [LEN_W-1:0]       length,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      checksum,
    nois_mem_copy_master_if.master avm
);

    state_t              state_r, next_state_s;
    logic [ADDR_W-1:0]   src_ptr_r, src_ptr_s;
    logic [ADDR_W-1:0]   dst_ptr_r, dst_ptr_s;
    logic [LEN_W-1:0]    remaining_r, remaining_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic [DATA_W-1:0]   checksum_r, checksum_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic                read_r, write_r, busy_r, done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (length == '0) ? FINISH : RD_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (!avm.avm_waitrequest) begin
                    next_state_s = RD_WAIT;
                end else begin
                    next_state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    next_state_s = WR_REQ;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (!avm.avm_waitrequest) begin
                    next_state_s = (remaining_r == LEN_W'(1)) ? FINISH : RD_REQ;
                end else begin
                    next_state_s = WR_REQ;
                end
            end
            FINISH:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath and request next-values; outputs follow next_state so they line up with the state.
    always_comb begin
        src_ptr_s   = src_ptr_r;
        dst_ptr_s   = dst_ptr_r;
        remaining_s = remaining_r;
        data_s      = data_r;
        checksum_s  = checksum_r;
        addr_s      = addr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    src_ptr_s   = src_addr;
                    dst_ptr_s   = dst_addr;
                    remaining_s = length;
                    checksum_s  = '0;
                end else begin
                    checksum_s  = checksum_r;
                end
            end
            RD_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    data_s     = avm.avm_readdata;
                    checksum_s = checksum_r + avm.avm_readdata;
                end else begin
                    data_s     = data_r;
                end
            end
            WR_REQ: begin
                if (!avm.avm_waitrequest) begin
                    src_ptr_s   = src_ptr_r + ADDR_W'(BYTES_PER_WORD);
                    dst_ptr_s   = dst_ptr_r + ADDR_W'(BYTES_PER_WORD);
                    remaining_s = remaining_r - LEN_W'(1);
                end else begin
                    remaining_s = remaining_r;
                end
            end
            default: begin
                data_s = data_r;
            end
        endcase
        if (next_state_s == RD_REQ) begin
            addr_s = src_ptr_s;
        end else if (next_state_s == WR_REQ) begin
            addr_s = dst_ptr_s;
        end else begin
            addr_s = addr_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr_r   <= '0;
            dst_ptr_r   <= '0;
            remaining_r <= '0;
            data_r      <= '0;
            checksum_r  <= '0;
            addr_r      <= '0;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            src_ptr_r   <= src_ptr_s;
            dst_ptr_r   <= dst_ptr_s;
            remaining_r <= remaining_s;
            data_r      <= data_s;
            checksum_r  <= checksum_s;
            addr_r      <= addr_s;
            read_r      <= (next_state_s == RD_REQ);
            write_r     <= (next_state_s == WR_REQ);
            busy_r      <= (next_state_s == RD_REQ) || (next_state_s == RD_WAIT) ||
                           (next_state_s == WR_REQ);
            done_r      <= (next_state_s == FINISH);
        end
    end

    assign busy               = busy_r;
    assign done               = done_r;
    assign checksum           = checksum_r;
    assign avm.avm_address    = addr_r;
    assign avm.avm_read       = read_r;
    assign avm.avm_write      = write_r;
    assign avm.avm_writedata  = data_r;
    assign avm.avm_byteenable = BE_ALL;

endmodule

// File: tb/tb_nois_mem_copy_master.sv
// Self-checking bench: Avalon slave memory model with stalls/latency, table of copy jobs,
// random jobs against a word-copy reference model, plus hand-written corner sequences.
module tb_nois_mem_copy_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    nois_mem_copy_master_if bus ();

    nois_mem_copy_master dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .avm      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave memory and reference copy of it.
    logic [31:0] mem  [1024];
    logic [31:0] expm [1024];

    int          stall_mode = 0;   // >=0 fixed stall per request, -1 random 0..3
    bit          lat_rand   = 1'b0;
    bit          in_req     = 1'b0;
    int          stall_left = 0;
    logic [31:0] cap_addr, cap_wd;
    logic        cap_rd, cap_wr;
    bit          rd_pend    = 1'b0;
    int          rd_cnt     = 0;
    logic [31:0] rd_data;
    int          n_reads    = 0;
    int          n_writes   = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          stall;
        bit          lrand;
        int          exp_cyc;   // 0: latency not checked
    } job_t;

    job_t jobs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Slave behaviour for the current cycle, evaluated on the falling edge.
    task automatic bfm_step();
        logic [31:0] a;
        a = bus.avm_address;
        bus.avm_readdatavalid = 1'b0;
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = rd_data;
                rd_pend               = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
        if (bus.avm_read || bus.avm_write) begin
            check("rd_wr_exclusive", {31'd0, bus.avm_read & bus.avm_write}, 32'd0);
            check("byteenable", {28'd0, bus.avm_byteenable}, 32'h0000000F);
            if (!in_req) begin
                in_req     = 1'b1;
                cap_addr   = a;
                cap_wd     = bus.avm_writedata;
                cap_rd     = bus.avm_read;
                cap_wr     = bus.avm_write;
                stall_left = (stall_mode >= 0) ? stall_mode : int'($urandom_range(0, 3));
            end else begin
                check("stall_addr", a, cap_addr);
                check("stall_data", bus.avm_writedata, cap_wd);
                check("stall_strobes", {30'd0, bus.avm_read, bus.avm_write}, {30'd0, cap_rd, cap_wr});
            end
            if (stall_left > 0) begin
                bus.avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_req = 1'b0;
                if (bus.avm_read) begin
                    rd_pend = 1'b1;
                    rd_cnt  = lat_rand ? 1 + int'($urandom_range(0, 2)) : 1;
                    rd_data = mem[a[11:2]];
                    n_reads++;
                end
                if (bus.avm_write) begin
                    mem[a[11:2]] = bus.avm_writedata;
                    n_writes++;
                end
            end
        end else begin
            bus.avm_waitrequest = 1'b0;
            in_req = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bfm_step();
        @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 1024; i++) expm[i] = mem[i];
    endtask

    // Reference: ascending word-by-word copy on the expected image, summing words as read.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                              output logic [31:0] sum);
        logic [31:0] sa, da, w;
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            w  = expm[sa[11:2]];
            expm[da[11:2]] = w;
            sum = sum + w;
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 1024; i++) begin
            if (mem[i] !== expm[i] && bad < 0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: mem[%0d] got %08h expected %08h", name, bad, mem[bad], expm[bad]);
        end
    endtask

    task automatic start_pulse(input logic [31:0] s, input logic [31:0] d, input int n);
        src_addr = s;
        dst_addr = d;
        length   = 11'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", k);
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] s, input logic [31:0] d,
                           input int n, input int stall, input bit lr, input int exp_cyc);
        logic [31:0] sum;
        int          k;
        stall_mode = stall;
        lat_rand   = lr;
        snapshot();
        model_copy(s, d, n, sum);
        start_pulse(s, d, n);
        wait_done(1, k);
        if (exp_cyc != 0) check({name, "_cycles"}, 32'(k), 32'(exp_cyc));
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({name, "_checksum"}, checksum, sum);
        check_mem({name, "_mem"});
        tick();
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] sum_a, sum_c;
        int          k, w0, r0;
        bit          done_seen;

        jobs[0] = '{32'h0000_0400, 32'h0000_0800, 1, 0, 1'b0, 5};
        jobs[1] = '{32'h0000_0010, 32'h0000_0C00, 7, 5, 1'b0, 99};
        jobs[2] = '{32'h0000_0200, 32'h0000_0208, 6, 0, 1'b0, 25};
        jobs[3] = '{32'h0000_020C, 32'h0000_0204, 5, 0, 1'b0, 21};
        jobs[4] = '{32'hFFFF_FFF8, 32'h0000_0E00, 4, 0, 1'b0, 17};
        jobs[5] = '{32'h0000_0100, 32'hFFFF_FFFC, 3, 1, 1'b0, 19};
        jobs[6] = '{32'h0000_0300, 32'h0000_0F00, 10, -1, 1'b1, 0};

        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        bus.avm_readdata      = 32'd0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 32'd0;
        dst_addr = 32'd0;
        length   = 11'd0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_read", {31'd0, bus.avm_read}, 32'd0);
        check("rst_write", {31'd0, bus.avm_write}, 32'd0);
        check("rst_address", bus.avm_address, 32'd0);
        check("rst_writedata", bus.avm_writedata, 32'd0);
        check("rst_byteenable", {28'd0, bus.avm_byteenable}, 32'h0000000F);
        reset = 1'b0;
        tick();

        // Word copy: 4 words, done 4N+1 = 17 cycles after start.
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        run_job("word_copy", 32'h0000_0000, 32'h0000_0100, 4, 0, 1'b0, 17);
        for (int i = 0; i < 4; i++) check("word_copy_dst", mem[64 + i], 32'(i + 1));

        // Zero length: no bus traffic, done on the cycle after start, checksum cleared.
        r0 = n_reads;
        w0 = n_writes;
        run_job("zero_len", 32'h0000_0040, 32'h0000_0140, 0, 0, 1'b0, 1);
        check("zero_len_sum", checksum, 32'd0);
        check("zero_len_reads", 32'(n_reads - r0), 32'd0);
        check("zero_len_writes", 32'(n_writes - w0), 32'd0);

        // Checksum wrap.
        mem[32'h80] = 32'hFFFF_FFFF;
        mem[32'h81] = 32'h0000_0002;
        run_job("sum_wrap", 32'h0000_0200, 32'h0000_0280, 2, 0, 1'b0, 9);
        check("sum_wrap_value", checksum, 32'h0000_0001);

        // Table of jobs: stalls, overlap both ways, address wrap, random latency.
        for (int j = 0; j < 7; j++) begin
            run_job($sformatf("tbl%0d", j), jobs[j].src, jobs[j].dst, jobs[j].len,
                    jobs[j].stall, jobs[j].lrand, jobs[j].exp_cyc);
        end

        // Random jobs with random stalls and read latency.
        for (int j = 0; j < 6; j++) begin
            run_job($sformatf("rnd%0d", j), $urandom() & 32'hFFFF_FFFC,
                    $urandom() & 32'hFFFF_FFFC, int'($urandom_range(1, 12)), -1, 1'b1, 0);
        end

        // Reset after the 3rd write of an 8-word job.
        stall_mode = 0;
        lat_rand   = 1'b0;
        snapshot();
        model_copy(32'h0000_0A00, 32'h0000_0B00, 3, sum_a);
        w0 = n_writes;
        start_pulse(32'h0000_0A00, 32'h0000_0B00, 8);
        k = 0;
        while (n_writes - w0 < 3 && k < 200) begin
            tick();
            k++;
        end
        check("abort_third_write", 32'(n_writes - w0), 32'd3);
        reset = 1'b1;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_read", {31'd0, bus.avm_read}, 32'd0);
        check("abort_write", {31'd0, bus.avm_write}, 32'd0);
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            tick();
            done_seen = done_seen | done;
        end
        check("abort_no_done", {31'd0, done_seen}, 32'd0);
        check("abort_checksum", checksum, 32'd0);
        check_mem("abort_mem");

        // start while busy ignored; start in FINISH ignored; start after done accepted.
        snapshot();
        model_copy(32'h0000_0300, 32'h0000_0380, 4, sum_a);
        start_pulse(32'h0000_0300, 32'h0000_0380, 4);
        repeat (3) tick();
        src_addr = 32'h0000_0000;
        dst_addr = 32'h0000_0500;
        length   = 11'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(5, k);
        check("busy_start_cycles", 32'(k), 32'd17);
        check("busy_start_checksum", checksum, sum_a);
        check_mem("busy_start_mem");
        model_copy(32'h0000_0040, 32'h0000_0600, 2, sum_c);
        src_addr = 32'h0000_0040;
        dst_addr = 32'h0000_0600;
        length   = 11'd2;
        start    = 1'b1;
        tick();
        check("finish_start_ignored", {31'd0, busy}, 32'd0);
        tick();
        start    = 1'b0;
        check("after_done_accepted", {31'd0, busy}, 32'd1);
        wait_done(1, k);
        check("after_done_cycles", 32'(k), 32'd9);
        check("after_done_checksum", checksum, sum_c);
        check_mem("after_done_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
